// File: rtl/fetch_queue_if.sv
// fetch_queue_if: memory read bus and decode handshake
// for the LC-3 fetch queue.
interface fetch_queue_if #(
  parameter int AW = 16
);
  logic [AW-1:0] addr_out;
  logic          wea_out;
  logic          rd_req;
  logic [15:0]   rdata_in;
  logic          rdata_valid;
  logic [15:0]   instr_out;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;

  modport master (
    output addr_out,
    output wea_out,
    output rd_req,
    input  rdata_in,
    input  rdata_valid,
    output instr_out,
    output instr_pc,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  addr_out,
    input  wea_out,
    input  rd_req,
    output rdata_in,
    output rdata_valid,
    input  instr_out,
    input  instr_pc,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: LC-3 fetch unit with in-order prefetch queue.
// Optional FETCH_BYPASS_EN: empty-queue words pass straight to decode.
module fetch_queue #(
  parameter int            AW       = 16,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] PC_RESET = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_start,
  input  logic          resolve_valid,
  input  logic [3:0]    opCode_in,
  input  logic [8:0]    offset_in,
  input  logic [AW-1:0] reg_in,
  input  logic [AW-1:0] resolve_pc,
  input  logic [2:0]    br_nzp,
  input  logic [2:0]    result_nzp,
  output logic [AW-1:0] pc,
  fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [15:0]   word;
    logic [AW-1:0] pc;
  } entry_t;

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_addr;
  entry_t        r_q [DEPTH];
  logic [PW-1:0] r_qw;
  logic [PW-1:0] r_qr;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_tag [DEPTH];
  logic [PW-1:0] r_tw;
  logic [PW-1:0] r_tr;
  logic [CW-1:0] r_outs;
  logic [CW-1:0] r_disc;

  logic          w_is_br;
  logic          w_is_jmp;
  logic          w_taken;
  logic          w_redirect;
  logic [AW-1:0] w_off;
  logic [AW-1:0] w_target;
  logic [CW:0]   w_used;
  logic          w_issue;
  logic          w_drop;
  logic          w_arrive;
  logic          w_qempty;
  logic          w_byp;
  logic          w_push;
  logic          w_pop;
  entry_t        w_head;

  assign w_is_br  = (opCode_in == 4'b0000);
  assign w_is_jmp = (opCode_in == 4'b1100);
  assign w_taken  = |(br_nzp & result_nzp);
  assign w_off    = AW'($signed(offset_in));

  assign w_redirect = resolve_valid
                    & ((w_is_br & w_taken) | w_is_jmp);

  // Redirect target: JMP takes the base register, BR is PC-relative
  always_comb begin
    unique case (1'b1)
      w_is_jmp: w_target = reg_in;
      default:  w_target = resolve_pc + AW'(1) + w_off;
    endcase
  end

  // Credits cover both buffered words and words still in flight
  assign w_used  = {1'b0, r_cnt} + {1'b0, r_outs};
  assign w_issue = fetch_start & ~w_redirect & (w_used < LIM);

  assign w_drop   = bus.rdata_valid & (r_disc != '0);
  assign w_arrive = bus.rdata_valid & (r_disc == '0)
                  & ~w_redirect;
  assign w_qempty = (r_cnt == '0);
  assign w_head   = r_q[r_qr];

`ifdef FETCH_BYPASS_EN
  assign w_byp  = w_arrive & w_qempty;
  assign w_push = w_arrive & ~(w_byp & bus.instr_ready);
`else
  assign w_byp  = 1'b0;
  assign w_push = w_arrive;
`endif

  assign w_pop = ~w_qempty & bus.instr_ready;

  assign pc           = r_pc;
  assign bus.rd_req   = w_issue;
  assign bus.addr_out = w_issue ? r_pc : r_addr;
  assign bus.wea_out  = 1'b0;

  assign bus.instr_valid = ~w_qempty | w_byp;
  assign bus.instr_out   = w_byp ? bus.rdata_in : w_head.word;
  assign bus.instr_pc    = w_byp ? r_tag[r_tr] : w_head.pc;

  // Fetch PC and held read address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= PC_RESET;
      r_addr <= '0;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (w_issue) begin
      r_pc   <= r_pc + AW'(1);
      r_addr <= r_pc;
    end
  end

  // Request-address tags, in-flight count and stale-response count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
      r_tw   <= '0;
      r_tr   <= '0;
      r_outs <= '0;
      r_disc <= '0;
    end else begin
      if (w_issue) begin
        r_tag[r_tw] <= r_pc;
        r_tw        <= r_tw + PW'(1);
      end
      if (bus.rdata_valid) r_tr <= r_tr + PW'(1);
      r_outs <= r_outs + CW'(w_issue)
              - CW'(bus.rdata_valid);
      if (w_redirect)
        r_disc <= r_outs - CW'(bus.rdata_valid);
      else if (w_drop)
        r_disc <= r_disc - CW'(1);
    end
  end

  // Instruction queue; a redirect flushes it after any pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_qw  <= '0;
      r_qr  <= '0;
      r_cnt <= '0;
    end else if (w_redirect) begin
      r_qw  <= '0;
      r_qr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_q[r_qw] <= '{word: bus.rdata_in, pc: r_tag[r_tr]};
        r_qw      <= r_qw + PW'(1);
      end
      if (w_pop) r_qr <= r_qr + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vectors, hand sequences and a randomized
// run against a stream-level model of the fetch queue.
module tb_fetch_queue;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        fs, rv, fs2;
  logic [3:0]  op;
  logic [8:0]  off;
  logic [15:0] regv, rpc, pc, pc2;
  logic [2:0]  brn, resn;

  fetch_queue_if #(.AW(AW)) bus ();
  fetch_queue_if #(.AW(AW)) bus2 ();

  fetch_queue #(.AW(AW), .DEPTH(DEPTH), .PC_RESET(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fs),
    .resolve_valid(rv), .opCode_in(op), .offset_in(off),
    .reg_in(regv), .resolve_pc(rpc), .br_nzp(brn),
    .result_nzp(resn), .pc(pc), .bus(bus)
  );

  fetch_queue #(.AW(AW), .DEPTH(DEPTH), .PC_RESET(16'hFFFE)) dut2 (
    .clk(clk), .rst_n(rst_n), .fetch_start(fs2),
    .resolve_valid(1'b0), .opCode_in(4'b0000),
    .offset_in(9'h000), .reg_in(16'h0000),
    .resolve_pc(16'h0000), .br_nzp(3'b000),
    .result_nzp(3'b000), .pc(pc2), .bus(bus2)
  );

  int nerr = 0;
  int nchk = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] word(logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  typedef struct { logic [15:0] a; int due; int ep; } req_t;
  typedef struct { logic [15:0] pc; logic [15:0] w; } dl_t;

  req_t        mq[$];
  dl_t         dlog[$];
  logic [15:0] rlog[$];
  logic [15:0] rlog2[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;

  // Memory model plus stream-level reference checker
  initial begin
    logic [15:0] m_fpc, m_dpc, tgt;
    int held, epoch, cur_ep, pend, sx, due;
    bit redir;
    m_fpc = 16'h0000; m_dpc = 16'h0000;
    held = 0; epoch = 0; cur_ep = 0;
    bus.rdata_valid = 1'b0; bus.rdata_in = 16'h0000;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        mq.delete();
        bus.rdata_valid = 1'b0;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.rdata_valid = 1'b1;
        bus.rdata_in    = word(mq[0].a);
        cur_ep          = mq[0].ep;
        void'(mq.pop_front());
      end else begin
        bus.rdata_valid = 1'b0;
      end
      @(negedge clk);
      if (rst_n && bus2.rd_req) rlog2.push_back(bus2.addr_out);
      if (!rst_n) begin
        chk("rst_pc", pc, 16'h0000);
        chk("rst_addr", bus.addr_out, 16'h0000);
        chk("rst_rdreq", bus.rd_req, 1'b0);
        chk("rst_valid", bus.instr_valid, 1'b0);
        chk("rst_instr", bus.instr_out, 16'h0000);
        chk("rst_ipc", bus.instr_pc, 16'h0000);
        chk("rst_wea", bus.wea_out, 1'b0);
        m_fpc = 16'h0000; m_dpc = 16'h0000;
        held = 0; epoch++;
        mq.delete();
      end else begin
        redir = rv && ((op == 4'b0000 && (brn & resn) != 3'b000)
                       || op == 4'b1100);
        sx  = off[8] ? int'(off) - 512 : int'(off);
        tgt = (op == 4'b1100) ? regv : 16'(int'(rpc) + 1 + sx);
        pend = mq.size() + (bus.rdata_valid ? 1 : 0);
        chk("rd_req", bus.rd_req,
            fs && !redir && (pend + held < DEPTH));
        chk("valid", bus.instr_valid, held > 0);
        chk("pc", pc, m_fpc);
        chk("wea", bus.wea_out, 1'b0);
        if (bus.rd_req) begin
          chk("addr", bus.addr_out, m_fpc);
          rlog.push_back(bus.addr_out);
          due = cyc + $urandom_range(lat_hi, lat_lo);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          mq.push_back('{a: bus.addr_out, due: due, ep: epoch});
        end
        if (bus.instr_valid && bus.instr_ready) begin
          chk("ipc", bus.instr_pc, m_dpc);
          chk("iword", bus.instr_out, word(m_dpc));
          dlog.push_back('{pc: bus.instr_pc, w: bus.instr_out});
          m_dpc++;
          if (held > 0) held--;
        end
        if (bus.rdata_valid && cur_ep == epoch && !redir) held++;
        if (redir) begin
          epoch++; held = 0;
          m_fpc = tgt; m_dpc = tgt;
        end else if (bus.rd_req) begin
          m_fpc++;
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    fs = 1'b0; rv = 1'b0; bus.instr_ready = 1'b1;
    cycles(20);
  endtask

  task automatic do_reset();
    fs = 1'b0; rv = 1'b0; bus.instr_ready = 1'b0;
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
  endtask

  task automatic set_res(logic [3:0] o, logic [2:0] b, logic [2:0] r,
                         logic [15:0] p, logic [8:0] f, logic [15:0] g);
    op = o; brn = b; resn = r; rpc = p; off = f; regv = g;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  brn;
    logic [2:0]  resn;
    logic [15:0] rpc;
    logic [8:0]  off;
    logic [15:0] regv;
    bit          taken;
    logic [15:0] tgt;
  } vec_t;

  initial begin
    vec_t tv[10];
    int b, n;
    logic [15:0] tpc, exp;
    tv[0] = '{4'b0000, 3'b010, 3'b010, 16'h0010, 9'h1F0, 16'h0000, 1'b1, 16'h0001};
    tv[1] = '{4'b0000, 3'b111, 3'b100, 16'h1234, 9'h005, 16'h0000, 1'b1, 16'h123A};
    tv[2] = '{4'b0000, 3'b001, 3'b010, 16'h5555, 9'h0FF, 16'h0000, 1'b0, 16'h0000};
    tv[3] = '{4'b1100, 3'b000, 3'b000, 16'h0000, 9'h000, 16'h3000, 1'b1, 16'h3000};
    tv[4] = '{4'b1001, 3'b111, 3'b111, 16'h4000, 9'h001, 16'h7777, 1'b0, 16'h0000};
    tv[5] = '{4'b0000, 3'b000, 3'b111, 16'h4000, 9'h001, 16'h0000, 1'b0, 16'h0000};
    tv[6] = '{4'b0000, 3'b100, 3'b100, 16'hFFFF, 9'h000, 16'h0000, 1'b1, 16'h0000};
    tv[7] = '{4'b0000, 3'b001, 3'b001, 16'h0000, 9'h100, 16'h0000, 1'b1, 16'hFF01};
    tv[8] = '{4'b1100, 3'b000, 3'b000, 16'h0000, 9'h000, 16'hFFFF, 1'b1, 16'hFFFF};
    tv[9] = '{4'b0001, 3'b111, 3'b111, 16'h0000, 9'h000, 16'hABCD, 1'b0, 16'h0000};

    fs = 1'b0; rv = 1'b0; fs2 = 1'b0;
    set_res(4'b1001, 3'b000, 3'b000, 16'h0000, 9'h000, 16'h0000);
    bus.instr_ready = 1'b0;
    bus2.rdata_valid = 1'b0; bus2.rdata_in = 16'h0000;
    bus2.instr_ready = 1'b1;

    // Reset held 5 cycles, then idle with fetch_start low
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    fs2 = 1'b1;
    cycles(4);
    chk("idle_nreq", rlog.size(), 0);
    chk("idle_pc", pc, 16'h0000);
    chk("idle_addr", bus.addr_out, 16'h0000);

    // Latency-2 stream with decode always ready
    lat_lo = 2; lat_hi = 2;
    b = dlog.size();
    bus.instr_ready = 1'b1; fs = 1'b1;
    cycles(8);
    fs = 1'b0;
    cycles(10);
    chk("seq_len", dlog.size() >= b + 3, 1'b1);
    for (int i = 0; i < 3; i++)
      if (b + i < dlog.size()) begin
        chk("seq_pc", dlog[b+i].pc, 16'(i));
        chk("seq_word", dlog[b+i].w, 16'h1000 + 16'(i));
      end

    // Full queue: four requests, then one pop buys one more
    do_reset();
    lat_lo = 1; lat_hi = 1;
    b = rlog.size();
    fs = 1'b1;
    cycles(10);
    chk("full_nreq", rlog.size() - b, 4);
    for (int i = 0; i < 4; i++)
      if (b + i < rlog.size()) chk("full_addr", rlog[b+i], 16'(i));
    chk("full_pc", pc, 16'h0004);
    chk("full_stall", bus.rd_req, 1'b0);
    bus.instr_ready = 1'b1;
    cycles(1);
    bus.instr_ready = 1'b0;
    cycles(6);
    chk("pop_nreq", rlog.size() - b, 5);
    if (b + 4 < rlog.size()) chk("pop_addr", rlog[b+4], 16'h0004);
    drain();

    // Taken BR with two requests in flight
    do_reset();
    lat_lo = 3; lat_hi = 3;
    b = rlog.size(); n = dlog.size();
    bus.instr_ready = 1'b1; fs = 1'b1;
    cycles(2);
    chk("flush_inflight", rlog.size() - b, 2);
    set_res(4'b0000, 3'b010, 3'b010, 16'h0010, 9'h1F0, 16'h0000);
    rv = 1'b1;
    cycles(1);
    rv = 1'b0;
    cycles(12);
    if (b + 2 < rlog.size()) chk("flush_addr", rlog[b+2], 16'h0001);
    else chk("flush_addr_n", rlog.size() - b, 3);
    if (n < dlog.size()) begin
      chk("flush_ipc", dlog[n].pc, 16'h0001);
      chk("flush_word", dlog[n].w, 16'h1001);
    end else chk("flush_dlen", dlog.size() - n, 1);

    // BR not taken keeps the sequence, then JMP
    n = rlog.size();
    set_res(4'b0000, 3'b100, 3'b001, 16'h0002, 9'h040, 16'h0000);
    rv = 1'b1;
    cycles(1);
    rv = 1'b0;
    cycles(4);
    if (n < rlog.size() && n > 0)
      chk("nt_addr", rlog[n], rlog[n-1] + 16'h0001);
    else chk("nt_nreq", rlog.size() > n, 1'b1);
    n = rlog.size();
    set_res(4'b1100, 3'b000, 3'b000, 16'h0000, 9'h000, 16'h3000);
    rv = 1'b1;
    cycles(1);
    rv = 1'b0;
    cycles(6);
    if (n < rlog.size()) chk("jmp_addr", rlog[n], 16'h3000);
    else chk("jmp_nreq", rlog.size() > n, 1'b1);
    drain();

    // Redirect decode table, applied with fetch idle
    do_reset();
    tpc = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      set_res(tv[i].op, tv[i].brn, tv[i].resn,
              tv[i].rpc, tv[i].off, tv[i].regv);
      rv = 1'b1;
      cycles(1);
      rv = 1'b0;
      exp = tv[i].taken ? tv[i].tgt : tpc;
      chk($sformatf("vec%0d_pc", i), pc, exp);
      tpc = exp;
    end

    // Randomized traffic against the reference model
    do_reset();
    lat_lo = 1; lat_hi = 4;
    n = dlog.size();
    for (int i = 0; i < 3000; i++) begin
      fs = ($urandom % 8) != 0;
      bus.instr_ready = ($urandom % 4) != 0;
      rv = ($urandom % 16) == 0;
      case ($urandom % 4)
        0, 1:    op = 4'b0000;
        2:       op = 4'b1100;
        default: op = 4'($urandom);
      endcase
      brn = 3'($urandom); resn = 3'($urandom);
      off = 9'($urandom); regv = 16'($urandom);
      rpc = 16'($urandom);
      cycles(1);
    end
    drain();
    chk("rand_progress", dlog.size() - n > 200, 1'b1);

    // Second instance starts near the top of the address space
    chk("wrap_n", rlog2.size() >= 3, 1'b1);
    if (rlog2.size() >= 3) begin
      chk("wrap_a0", rlog2[0], 16'hFFFE);
      chk("wrap_a1", rlog2[1], 16'hFFFF);
      chk("wrap_a2", rlog2[2], 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised LC-3 instruction fetch unit with an in-order prefetch queue. It generates sequential read addresses into instruction memory and buffers the returned words in a DEPTH-entry FIFO. It hands instructions to decode over a valid/ready handshake. It redirects the PC when execute resolves a taken BR or a JMP, flushing buffered words and discarding in-flight responses. It sits between instruction memory and the decode stage.

## Interface
Parameters:
- AW, 16, address and PC width; must be at least 9.
- DEPTH, 4, prefetch queue entries; a power of two, at least 2.
- PC_RESET, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_start  in  1  allows new memory requests while high.
- resolve_valid  in  1  execute presents a control-flow instruction this cycle.
- opCode_in  in  4  opcode of the resolving instruction.
- offset_in  in  9  PCoffset9 of the resolving instruction.
- reg_in  in  AW  base register value, used by JMP.
- resolve_pc  in  AW  address of the resolving instruction.
- br_nzp  in  3  BR condition bits.
- result_nzp  in  3  current condition codes.
- addr_out  out  AW  memory read address.
- wea_out  out  1  memory write enable; held at 0.
- rd_req  out  1  read request; addr_out is valid while it is high.
- rdata_in  in  16  memory read data.
- rdata_valid  in  1  read data valid; responses return in request order, with latency of 1 or more cycles.
- instr_out  out  16  head-of-queue instruction.
- instr_pc  out  AW  address of instr_out.
- instr_valid  out  1  queue is non-empty.
- instr_ready  in  1  decode accepts the head entry.
- pc  out  AW  next fetch address.

## Operation
- Reset values:
  - pc = PC_RESET
  - addr_out = 0, wea_out = 0, rd_req = 0
  - instr_out = 0, instr_pc = 0, instr_valid = 0
  - queue empty; outstanding and discard counters = 0
- Issue rule: rd_req = fetch_start and no redirect this cycle and (count + outstanding < DEPTH).
  - While rd_req is high, addr_out = pc; pc increments on that edge.
  - While rd_req is low, addr_out holds its last value.
- Response handling: each rdata_valid decrements outstanding.
  - If discard > 0, the word is dropped and discard decrements.
  - Otherwise {rdata_in, tag PC} is pushed. The tag PC comes from an internal request-address FIFO.
- Pop: the head entry is removed when instr_valid and instr_ready are both high.
- Redirect decode, evaluated only when resolve_valid is high:
  - BR (0000) is taken when |(br_nzp & result_nzp). Target = resolve_pc + 1 + sext(offset_in).
  - JMP/RET (1100): target = reg_in.
  - Any other opcode (e.g. NOT 1001), or a BR that is not taken, causes no action.
- Redirect effect, at the clock edge:
  - pc becomes the target.
  - The queue empties.
  - discard becomes outstanding (including any response arriving this cycle, which is also dropped).
  - No request issues in the redirect cycle.
- Arithmetic: all PC arithmetic is modulo 2^AW. offset_in is sign-extended from bit 8.

## Timing
- Request to queue: a word returned on cycle N is visible on instr_out at cycle N+1 (registered).
- Boundaries:
  - fetch_start low: no requests; outstanding responses still fill the queue and the queue still drains. Reasserting fetch_start resumes at the current pc.
  - Full: count + outstanding = DEPTH stalls issue. A pop in the same cycle frees a slot for the next cycle, not the current one.
  - Push and pop together: count is unchanged. Pop when empty is ignored. Push is never issued to a full queue, by construction of the credit rule.
  - Redirect together with pop: the pop completes, then the flush applies; instr_valid = 0 on the next cycle.
  - Redirect together with push: the push is dropped.
  - pc = 2^AW-1 wraps to 0.
  - Reset mid-operation clears all state immediately. Responses arriving after reset that were not requested after reset are outside this block's contract; memory is reset together with this block.

## Configuration
- FETCH_BYPASS_EN defined:
  - When the queue is empty, rdata_valid and discard = 0, instr_out/instr_pc/instr_valid present the arriving word combinationally in the same cycle.
  - If instr_ready is high, the word is consumed and not pushed.
- FETCH_BYPASS_EN undefined: all output is registered, with minimum latency of one cycle from rdata_valid to instr_valid.

## Test plan
- Hold rst_n=0 for 5 cycles with fetch_start=0 and opCode_in=1001, then release. Required: addr_out=0, wea_out=0, pc=0, rd_req=0, instr_valid=0, and they stay so while fetch_start=0.
- fetch_start=1, memory latency 2 returning 0x1000+addr, instr_ready=1. Required: instr_out sequence 0x1000, 0x1001, 0x1002 with instr_pc 0, 1, 2, in order.
- DEPTH=4 with instr_ready=0. Required: exactly 4 requests (addr 0–3), then rd_req=0 and pc=4. One pop re-enables exactly one request, to addr 4.
- With 2 requests in flight, BR taken: resolve_pc=0x0010, offset_in=0x1F0, br_nzp=010, result_nzp=010. Required: the next request has addr_out=0x0001, both stale responses are dropped, and the first delivered instr_pc=0x0001.
- BR with br_nzp=100, result_nzp=001: no flush, sequence continues. Then JMP with reg_in=0x3000: the next addr_out is 0x3000.
- pc preloaded near the top with PC_RESET=0xFFFE and AW=16. Required: requests go to 0xFFFE, 0xFFFF, then 0x0000.
